t07_button_strobe_arbiter: RTL and testbench

- Front end for every button-driven FSM in the game (menu, mod locator, maze). Consumers sample `button` only when `strobe` is high.
- Synchronises and debounces the six raw push-buttons.
- Arbitrates simultaneous presses down to a single one-hot code.
- Emits one-cycle `strobe` pulses, with auto-repeat on held direction keys.

---
 rtl/t07_button_strobe_arbiter.sv | 165 ++++++++++++++++
 tb/tb_t07_button_strobe_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_button_strobe_arbiter.sv
// Button front end: two-flop synchroniser, shared-counter debounce,
// fixed-priority arbitration and one-cycle strobes with auto-repeat
// on held direction keys.
//
// Output contract: consumers sample `button` only in a cycle where
// strobe=1. In that cycle button is one-hot and nonzero. There is no
// back-pressure, so every strobe is a single-cycle event that must be
// taken when it occurs.
module t07_button_strobe_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [5:0] raw_button,
    input  logic       repeat_en,
    output logic [5:0] button,
    output logic       strobe,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        REPEAT  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [5:0]       s1_q, s2_q;
    logic [5:0]       deb_q;
    logic [CNT_W-1:0] dcnt_q;
    state_e           state_q, state_d;
    logic [5:0]       button_q, button_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [5:0]       grant;
    logic             held;
    logic             is_dir;

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q <= 6'b0;
            s2_q <= 6'b0;
        end else begin
            s1_q <= raw_button;
            s2_q <= s1_q;
        end
    end

    // Shared debounce counter: any difference must persist unchanged-back
    // for DEBOUNCE_CYCLES cycles; a bounce back to deb restarts the count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            deb_q  <= 6'b0;
            dcnt_q <= '0;
        end else if (s2_q == deb_q) begin
            dcnt_q <= '0;
        end else if (dcnt_q == DEB_LAST) begin
            deb_q  <= s2_q;
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_q + 1'b1;
        end
    end

    // Fixed priority: BACK, SELECT, UP, RIGHT, DOWN, LEFT.
    always_comb begin
        grant = 6'b0;
        if      (deb_q[5]) grant = 6'b100000;
        else if (deb_q[0]) grant = 6'b000001;
        else if (deb_q[1]) grant = 6'b000010;
        else if (deb_q[2]) grant = 6'b000100;
        else if (deb_q[3]) grant = 6'b001000;
        else if (deb_q[4]) grant = 6'b010000;
    end

    assign held   = |(deb_q & button_q);
    assign is_dir = |button_q[4:1];

    // Grant / hold / repeat / release sequencing.
    always_comb begin
        state_d  = state_q;
        button_d = button_q;
        strobe_d = 1'b0;
        rcnt_d   = rcnt_q;
        case (state_q)
            IDLE: begin
                button_d = 6'b0;
                if (deb_q != 6'b0) begin
                    button_d = grant;
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!held) begin
                    button_d = 6'b0;
                    state_d  = RELEASE;
                end else if (is_dir && repeat_en && rcnt_q == RD_LAST) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    state_d  = REPEAT;
                end else if (is_dir && !repeat_en) begin
                    // Keep the delay re-armed so re-enabling repeat waits a full delay.
                    rcnt_d = '0;
                end else if (rcnt_q != CNT_MAX) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!held) begin
                    button_d = 6'b0;
                    state_d  = RELEASE;
                end else if (!repeat_en) begin
                    rcnt_d  = '0;
                    state_d = HOLD;
                end else if (rcnt_q == RP_LAST) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                button_d = 6'b0;
                if (deb_q == 6'b0) state_d = IDLE;
            end
            default: begin
                button_d = 6'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            button_q <= 6'b0;
            strobe_q <= 1'b0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            strobe_q <= strobe_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign button    = button_q;
    assign strobe    = strobe_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_t07_button_strobe_arbiter.sv
module tb_t07_button_strobe_arbiter;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] raw_button;
  logic       repeat_en;
  logic [5:0] button;
  logic       strobe;
  logic       busy;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic prev_strobe = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_t[$];
  logic [5:0]  obs_b[$];

  t07_button_strobe_arbiter #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(16)
  ) dut (
    .clk(clk), .nrst(nrst), .raw_button(raw_button), .repeat_en(repeat_en),
    .button(button), .strobe(strobe), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobe monitor: records the edge number that produced each strobe
  always @(negedge clk) begin
    if (nrst === 1'b1 && strobe === 1'b1) begin
      obs_t.push_back(cyc);
      obs_b.push_back(button);
      chk("strobe_onehot", {31'b0, $onehot(button)}, 32'd1);
      if (prev_strobe) chk("strobe_back_to_back", 32'd1, 32'd0);
    end
    prev_strobe = (nrst === 1'b1) && (strobe === 1'b1);
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference: highest-priority pressed key as a one-hot code
  function automatic logic [5:0] ref_grant(logic [5:0] m);
    int prio[6] = '{5, 0, 1, 2, 3, 4};
    for (int i = 0; i < 6; i++)
      if (m[prio[i]]) return 6'(1 << prio[i]);
    return 6'b0;
  endfunction

  function automatic bit ref_is_dir(logic [5:0] g);
    return (g[1] | g[2] | g[3] | g[4]);
  endfunction

  // repeat strobes every RP edges starting at 'start', strictly before the release edge
  task automatic model_repeats(int start, int rel);
    for (int t = start; t < rel; t += RP) exp_q.push_back(t);
  endtask

  task automatic model_press(int g, int rel, bit rep);
    exp_q.push_back(g);
    if (rep) model_repeats(g + RD, rel);
  endtask

  task automatic check_strobes(string tag, logic [5:0] g);
    chk({tag, "_count"}, obs_t.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_t.size(); i++) begin
      chk({tag, "_time"}, obs_t[i], exp_q[i]);
      chk({tag, "_button"}, {26'b0, obs_b[i]}, {26'b0, g});
    end
    obs_t.delete();
    obs_b.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_idle_button"}, {26'b0, button}, 32'd0);
  endtask

  // press mask, hold it 'hold' cycles past the first strobe, release
  task automatic run_press(string tag, logic [5:0] mask, logic ren, int hold);
    int c0, g, c1, rel;
    logic [5:0] gr;
    gr = ref_grant(mask);
    repeat_en = ren;
    c0 = cyc;
    raw_button = mask;
    g = c0 + D + 3;
    step(D + 3);
    chk({tag, "_held_button"}, {26'b0, button}, {26'b0, gr});
    chk({tag, "_held_busy"}, {31'b0, busy}, 32'd1);
    step(hold);
    c1 = cyc;
    raw_button = 6'b0;
    rel = c1 + D + 3;
    model_press(g, rel, ref_is_dir(gr) && ren);
    wait_idle(tag);
    step(2);
    check_strobes(tag, gr);
  endtask

  initial begin
    int c0, g, c1, rel, cr, cn;
    nrst = 1'b0;
    raw_button = 6'b0;
    repeat_en = 1'b0;
    step(2);
    chk("reset_button", {26'b0, button}, 32'd0);
    chk("reset_strobe", {31'b0, strobe}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_state", {30'b0, dbg_state}, 32'd0);
    nrst = 1'b1;
    step(3);

    // UP held clean, no repeat
    run_press("up_clean", 6'b000010, 1'b0, 20);

    // UP bouncing every 2 cycles, then stable
    repeat_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      raw_button = (i % 2 == 0) ? 6'b000010 : 6'b000000;
      step(2);
    end
    c0 = cyc;
    raw_button = 6'b000010;
    g = c0 + D + 3;
    step(D + 3 + 10);
    c1 = cyc;
    raw_button = 6'b0;
    model_press(g, c1 + D + 3, 1'b0);
    wait_idle("bounce");
    step(2);
    check_strobes("bounce", 6'b000010);

    // BACK+RIGHT+SELECT together, then BACK released alone
    c0 = cyc;
    raw_button = 6'b100101;
    g = c0 + D + 3;
    step(D + 3 + 5);
    chk("multi_button", {26'b0, button}, 32'h20);
    raw_button = 6'b000101;
    step(12);
    chk("multi_partial_button", {26'b0, button}, 32'd0);
    chk("multi_partial_busy", {31'b0, busy}, 32'd1);
    raw_button = 6'b0;
    exp_q.push_back(g);
    wait_idle("multi");
    step(2);
    check_strobes("multi", 6'b100000);

    // DOWN auto-repeat, then SELECT never repeats
    run_press("down_repeat", 6'b001000, 1'b1, 23);
    run_press("select_norepeat", 6'b000001, 1'b1, 30);

    // LEFT in REPEAT, drop and re-raise repeat_en
    repeat_en = 1'b1;
    c0 = cyc;
    raw_button = 6'b010000;
    g = c0 + D + 3;
    step(D + 3 + RD + 2);
    repeat_en = 1'b0;
    exp_q.push_back(g);
    exp_q.push_back(g + RD);
    step(20);
    chk("left_paused_busy", {31'b0, busy}, 32'd1);
    cr = cyc;
    repeat_en = 1'b1;
    step(10);
    c1 = cyc;
    raw_button = 6'b0;
    rel = c1 + D + 3;
    model_repeats(cr + RD, rel);
    wait_idle("left_pause");
    step(2);
    check_strobes("left_pause", 6'b010000);

    // asynchronous reset mid-REPEAT with the key still held
    repeat_en = 1'b1;
    c0 = cyc;
    raw_button = 6'b010000;
    g = c0 + D + 3;
    step(D + 3 + RD);
    chk("pre_reset_strobe", {31'b0, strobe}, 32'd1);
    exp_q.push_back(g);
    #1 nrst = 1'b0;
    #1;
    chk("async_reset_button", {26'b0, button}, 32'd0);
    chk("async_reset_strobe", {31'b0, strobe}, 32'd0);
    chk("async_reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b1;
    cn = cyc;
    step(D + 3 + 10);
    c1 = cyc;
    raw_button = 6'b0;
    model_press(cn + D + 3, c1 + D + 3, 1'b1);
    wait_idle("reset_hold");
    step(2);
    check_strobes("reset_hold", 6'b010000);

    // randomized presses against the reference model
    for (int k = 0; k < 12; k++) begin
      logic [5:0] m;
      logic r;
      int h;
      m = 6'($urandom_range(1, 63));
      r = 1'($urandom_range(0, 1));
      h = $urandom_range(0, 25);
      run_press("random", m, r, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
